// File: rtl/data_mem_dump.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_mem_dump
// Brief    : Reads a contiguous window of data memory word by word and streams
//            each word with its address over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_dump #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              dump_done
);

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CAP  = 3'd2,
        S_HOLD = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur;
    logic [LEN_W-1:0]    r_rem;
    logic [LEN_W-1:0]    w_len_sat;

    // A window can never be longer than the whole address space.
    assign w_len_sat = (length > C_MAX_LEN) ? C_MAX_LEN : length;

    // The read address is the current-address register itself.
    assign mem_addr = r_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_rem     <= '0;
            mem_rd_en <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            dump_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (trig) begin
                        r_cur <= base_addr;
                        r_rem <= w_len_sat;
                        busy  <= 1'b1;
                        if (w_len_sat == '0) begin
                            r_state   <= S_FIN;
                            dump_done <= 1'b1;
                        end else begin
                            r_state   <= S_REQ;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    out_data  <= mem_rdata;
                    out_addr  <= r_cur;
                    out_last  <= (r_rem == LEN_W'(1));
                    out_valid <= 1'b1;
                    r_state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_rem     <= r_rem - LEN_W'(1);
                        if (out_last) begin
                            r_state   <= S_FIN;
                            dump_done <= 1'b1;
                        end else begin
                            r_cur     <= r_cur + ADDR_W'(1);
                            r_state   <= S_REQ;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Reads are always separated by at least the capture and hold cycles.
    a_rd_gap: assert property (@(posedge clk) disable iff (!rst_n)
                               mem_rd_en |=> !mem_rd_en);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_dump.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_dump
// Brief    : Randomized self-checking bench for data_mem_dump with a
//            queue-based model of the expected beat stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_dump;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              trig = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              dump_done;

    data_mem_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig      (trig),
        .base_addr (base_addr),
        .length    (length),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .dump_done (dump_done)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous read, garbage on the bus when not read.
    logic [DATA_W-1:0] mem [0:255];
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : DATA_W'($urandom);

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    n_asserts = 0;
    int    n_fail    = 0;
    int    rd_cnt    = 0;
    int    done_cnt  = 0;
    bit    zl_mode   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet_outs(input string pfx);
        check({pfx, "_rd_en"},  mem_rd_en, 0);
        check({pfx, "_maddr"},  mem_addr,  0);
        check({pfx, "_valid"},  out_valid, 0);
        check({pfx, "_data"},   out_data,  0);
        check({pfx, "_oaddr"},  out_addr,  0);
        check({pfx, "_last"},   out_last,  0);
        check({pfx, "_busy"},   busy,      0);
        check({pfx, "_done"},   dump_done, 0);
    endtask

    // Stream monitor: scoreboard pop, hold stability, read spacing, done timing.
    logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_rd = 1'b0, last_acc = 1'b0;
    logic [7:0] prev_data = '0, prev_addr = '0;

    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_rd    <= 1'b0;
            last_acc   <= 1'b0;
        end else begin
            if (mem_rd_en) rd_cnt <= rd_cnt + 1;
            if (dump_done) done_cnt <= done_cnt + 1;
            if (prev_rd) check("rd_gap", mem_rd_en, 0);
            if (prev_valid && !prev_ready) begin
                check("hold_valid", out_valid, 1);
                check("hold_data",  out_data,  prev_data);
                check("hold_addr",  out_addr,  prev_addr);
                check("hold_last",  out_last,  prev_last);
            end
            if (dump_done || last_acc) check("done_pulse", dump_done, last_acc | zl_mode);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", exp_q.size(), 1);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_addr", out_addr, b.addr);
                    check("beat_data", out_data, b.data);
                    check("beat_last", out_last, b.last);
                end
            end
            prev_valid <= out_valid;
            prev_ready <= out_ready;
            prev_data  <= out_data;
            prev_addr  <= out_addr;
            prev_last  <= out_last;
            prev_rd    <= mem_rd_en;
            last_acc   <= out_valid && out_ready && out_last;
        end
    end

    task automatic run_dump(input logic [7:0] base, input int len, input int pct,
                            input int stall_addr, input bit tog, input bit lat);
        int n, rd0, dn0, stall;
        bit seen;
        n = (len > 256) ? 256 : len;
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            exp_q.push_back('{addr: a, data: mem[a], last: (i == n - 1)});
        end
        rd0 = rd_cnt;
        dn0 = done_cnt;
        zl_mode = (n == 0);
        stall = 0;
        seen = 1'b0;
        @(posedge clk); #1;
        base_addr = base;
        length    = LEN_W'(len);
        trig      = 1'b1;
        out_ready = ($urandom_range(99) < pct);
        @(posedge clk); #1;
        trig      = 1'b0;
        base_addr = ADDR_W'($urandom);
        length    = LEN_W'($urandom);
        out_ready = ($urandom_range(99) < pct);
        for (int k = 0; k < 20 * n + 20; k++) begin
            @(negedge clk);
            if (lat && k == 0) begin
                check("lat_rd_en", mem_rd_en, 1);
                check("lat_maddr", mem_addr, base);
                check("lat_busy", busy, 1);
            end
            if (lat && k == 1) begin
                check("lat_rd_off", mem_rd_en, 0);
                check("lat_novalid", out_valid, 0);
            end
            if (lat && k == 2) begin
                check("lat_valid", out_valid, 1);
                check("lat_oaddr", out_addr, base);
            end
            if (n == 0 && k == 0) begin
                check("zl_busy", busy, 1);
                check("zl_done", dump_done, 1);
                check("zl_rd", mem_rd_en, 0);
                check("zl_valid", out_valid, 0);
            end
            if (dump_done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (stall_addr >= 0 && out_valid && out_addr == stall_addr[7:0] && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = ($urandom_range(99) < pct);
            end
            if (tog) trig = 1'($urandom_range(1));
        end
        trig = 1'b0;
        check("done_seen", seen, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_busy", busy, 0);
        check("post_done", dump_done, 0);
        check("post_valid", out_valid, 0);
        check("beats_left", exp_q.size(), 0);
        check("rd_count", rd_cnt - rd0, n);
        check("done_count", done_cnt - dn0, 1);
        exp_q.delete();
        zl_mode = 1'b0;
    endtask

    task automatic reset_mid_dump();
        bit found;
        int dn0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a;
            a = 8'h40 + 8'(i);
            exp_q.push_back('{addr: a, data: mem[a], last: (i == 3)});
        end
        @(posedge clk); #1;
        base_addr = 8'h40;
        length    = 9'd4;
        trig      = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        trig = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid && out_addr == 8'h41) begin
                found = 1'b1;
                out_ready = 1'b0;
                break;
            end
            out_ready = out_valid && (out_addr == 8'h40);
        end
        check("mid_hold_reached", found, 1);
        #2;
        rst_n = 1'b0;
        dn0 = done_cnt;
        #1;
        check_quiet_outs("mid_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("no_done_in_rst", done_cnt - dn0, 0);
        run_dump(8'h90, 3, 100, -1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet_outs("reset");
        rst_n = 1'b1;

        mem[0] = 8'h0F; mem[1] = 8'h0C; mem[2] = 8'h00; mem[3] = 8'h1B;
        run_dump(8'h00, 4, 100, -1, 1'b0, 1'b1);
        run_dump(8'h00, 4, 100, 1, 1'b0, 1'b0);

        mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hB2; mem[8'h00] = 8'hC3;
        run_dump(8'hFE, 3, 100, -1, 1'b0, 1'b0);

        run_dump(8'h10, 0, 100, -1, 1'b0, 1'b0);
        run_dump(8'h20, 4, 60, -1, 1'b1, 1'b0);
        reset_mid_dump();
        run_dump(8'h80, 300, 100, -1, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            run_dump(8'($urandom_range(255)), $urandom_range(24), $urandom_range(20, 100),
                     -1, 1'($urandom_range(1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
